// File: rtl/prog_run_ctrl.sv
// Run supervisor for the 9-bit-ISA core. It handles the start handshake, program
// slot selection, core reset/run gating, halt and stuck-PC detection, a watchdog
// and a saturating cycle count.
// Ports: clk/reset (synchronous, active-high); start (level, fall launches), prog_sel;
//        pc/instruction from the core; core_reset/core_run/start_pc drive the core;
//        done/timeout/busy/halt_cause/cycle_count report the run status.
// Latency: every output is registered, so status flags appear one cycle after detection.
// Backpressure: none. The core is gated through core_run, and start is sampled every cycle.
module prog_run_ctrl #(
    parameter int        PC_W        = 7,
    parameter int        INST_W      = 9,
    parameter int        CYC_W       = 10,
    parameter int        TIMEOUT     = 1000,
    parameter logic [2:0] HALT_OPC   = 3'b111,
    parameter int        STALL_LIM   = 2,
    parameter int        NUM_PROGS   = 4,
    parameter int        PROG_STRIDE = 32,
    localparam int       SW          = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SW-1:0]     prog_sel,
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] instruction,
    output logic              core_reset,
    output logic              core_run,
    output logic [PC_W-1:0]   start_pc,
    output logic              done,
    output logic              timeout,
    output logic              busy,
    output logic [1:0]        halt_cause,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int SC_W = (STALL_LIM > 1) ? $clog2(STALL_LIM + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        HALTED,
        TIMED_OUT
    } state_t;

    state_t          state;
    logic            start_q;
    logic [SW-1:0]   prog_sel_q;
    logic [PC_W-1:0] pc_prev;
    logic [SC_W-1:0] stall_cnt;
    logic            first_cyc;

    logic            start_rise;
    logic            start_fall;
    logic            halt_hit;
    logic            stall_hit;
    logic            tmo_hit;
    logic [SW-1:0]   sel_slot;

    assign start_rise = start & ~start_q;
    assign start_fall = ~start & start_q;

    // The halt opcode only counts when all of its operand bits are zero.
    assign halt_hit = (instruction[INST_W-1 -: 3] == HALT_OPC) &&
                      (instruction[INST_W-4:0] == '0);

    // stall_cnt already holds STALL_LIM-1 consecutive repeats, so one more
    // repeat completes the stall. The first RUN cycle has no valid pc_prev.
    assign stall_hit = !first_cyc && (pc == pc_prev) &&
                       (stall_cnt == SC_W'(STALL_LIM - 1));

    assign tmo_hit = (cycle_count == CYC_W'(TIMEOUT - 1));

    // Slot indices outside the populated range fall back to slot 0.
    assign sel_slot = (32'(prog_sel) >= NUM_PROGS) ? '0 : prog_sel;

    // The entry PC is a constant multiple of a registered slot index. It only
    // changes when prog_sel_q is relatched, and it wraps modulo 2**PC_W.
    assign start_pc = PC_W'(32'(prog_sel_q) * PROG_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            prog_sel_q  <= '0;
            pc_prev     <= '0;
            stall_cnt   <= '0;
            first_cyc   <= 1'b0;
            core_reset  <= 1'b1;
            core_run    <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            halt_cause  <= 2'd0;
            cycle_count <= '0;
        end else begin
            start_q <= start;
            if (start_rise) begin
                // A rising edge on start re-arms from any state and aborts a live run.
                state       <= ARMED;
                prog_sel_q  <= sel_slot;
                done        <= 1'b0;
                timeout     <= 1'b0;
                halt_cause  <= 2'd0;
                cycle_count <= '0;
                core_reset  <= 1'b1;
                core_run    <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        core_reset <= 1'b1;
                        core_run   <= 1'b0;
                        busy       <= 1'b0;
                    end
                    ARMED: begin
                        if (start_fall) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                            core_run   <= 1'b1;
                            busy       <= 1'b1;
                            first_cyc  <= 1'b1;
                            stall_cnt  <= '0;
                        end
                    end
                    RUN: begin
                        if (cycle_count != '1) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        pc_prev   <= pc;
                        first_cyc <= 1'b0;
                        if (!first_cyc) begin
                            stall_cnt <= (pc == pc_prev) ? SC_W'(stall_cnt + 1'b1) : '0;
                        end
                        if (halt_hit || stall_hit) begin
                            state      <= HALTED;
                            done       <= 1'b1;
                            halt_cause <= halt_hit ? 2'd1 : 2'd2;
                            core_run   <= 1'b0;
                            core_reset <= 1'b0;
                            busy       <= 1'b0;
                        end else if (tmo_hit) begin
                            state      <= TIMED_OUT;
                            timeout    <= 1'b1;
                            halt_cause <= 2'd3;
                            core_run   <= 1'b0;
                            core_reset <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end
                    HALTED, TIMED_OUT: begin
                        // The core is frozen but not reset, so its state can be inspected.
                        core_run   <= 1'b0;
                        core_reset <= 1'b0;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl, using directed runs followed by random program traces.
// Expected results come from a window-based reference model and are queued per run.
// A separate monitor pops the queue and checks when done or timeout rises.
module tb_prog_run_ctrl;

    localparam int TMO  = 20;
    localparam int SLIM = 2;
    localparam int NMAX = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] prog_sel;
    logic [6:0] pc;
    logic [8:0] instruction;
    logic       core_reset;
    logic       core_run;
    logic [6:0] start_pc;
    logic       done;
    logic       timeout;
    logic       busy;
    logic [1:0] halt_cause;
    logic [9:0] cycle_count;

    prog_run_ctrl #(
        .PC_W(7), .INST_W(9), .CYC_W(10), .TIMEOUT(TMO), .HALT_OPC(3'b111),
        .STALL_LIM(SLIM), .NUM_PROGS(4), .PROG_STRIDE(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .pc(pc), .instruction(instruction), .core_reset(core_reset),
        .core_run(core_run), .start_pc(start_pc), .done(done),
        .timeout(timeout), .busy(busy), .halt_cause(halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done;
        int tmo;
        int cause;
        int count;
        int spc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic       prev_fin = 1'b0;
    logic [6:0] prog_pc[NMAX];
    logic [8:0] prog_ins[NMAX];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int spc_of(input int sel);
        return (sel < 4) ? ((sel * 32) % 128) : 0;
    endfunction

    // Reference model. The run ends at the first RUN cycle k where the
    // instruction is exactly the halt word, or where the last SLIM+1 PCs are
    // all equal, or where k reaches TMO-1. Checks within a cycle go in that
    // priority order, and the reported count is k+1.
    function automatic exp_t model(input int sel);
        exp_t e;
        bit   same;
        e.spc = spc_of(sel);
        for (int k = 0; k < NMAX; k++) begin
            if (prog_ins[k] == 9'h1C0) begin
                e.done = 1; e.tmo = 0; e.cause = 1; e.count = k + 1;
                return e;
            end
            if (k >= SLIM) begin
                same = 1'b1;
                for (int j = 1; j <= SLIM; j++) begin
                    if (prog_pc[k-j] != prog_pc[k]) same = 1'b0;
                end
                if (same) begin
                    e.done = 1; e.tmo = 0; e.cause = 2; e.count = k + 1;
                    return e;
                end
            end
            if (k == TMO - 1) begin
                e.done = 0; e.tmo = 1; e.cause = 3; e.count = TMO;
                return e;
            end
        end
        e.done = 0; e.tmo = 0; e.cause = 0; e.count = 0;
        return e;
    endfunction

    // Monitor: on each new completion, pop the oldest expected result and compare.
    always @(negedge clk) begin
        if ((done | timeout) && !prev_fin) begin
            if (sb.size() == 0) begin
                chk("unexpected_finish", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done", done, mon_e.done);
                chk("timeout", timeout, mon_e.tmo);
                chk("halt_cause", halt_cause, mon_e.cause);
                chk("cycle_count", cycle_count, mon_e.count);
                chk("start_pc", start_pc, mon_e.spc);
                chk("core_run_off", core_run, 0);
                chk("busy_off", busy, 0);
            end
        end
        prev_fin = done | timeout;
    end

    task automatic launch(input int sel, input int hold);
        start    = 1'b1;
        prog_sel = sel[1:0];
        tick;
        chk("armed_start_pc", start_pc, spc_of(sel));
        chk("armed_core_reset", core_reset, 1);
        chk("armed_busy", busy, 0);
        // prog_sel changes while start is held and must not be sampled again.
        prog_sel = 2'(sel + 1);
        repeat (hold - 1) tick;
        chk("armed_hold_pc", start_pc, spc_of(sel));
        start = 1'b0;
        tick;
        chk("run_busy", busy, 1);
        chk("run_core_run", core_run, 1);
        chk("run_core_reset", core_reset, 0);
        chk("run_count_zero", cycle_count, 0);
    endtask

    task automatic run_prog(input int sel, input int hold);
        exp_t e;
        bit   ended;
        e = model(sel);
        sb.push_back(e);
        launch(sel, hold);
        ended = 1'b0;
        for (int k = 0; k < NMAX && !ended; k++) begin
            pc          = prog_pc[k];
            instruction = prog_ins[k];
            tick;
            if (!busy) ended = 1'b1;
        end
        if (!ended) chk("run_bound", 0, 1);
        tick;
        tick;
        chk("hold_flag", done | timeout, 1);
        chk("hold_count", cycle_count, e.count);
        chk("hold_core_run", core_run, 0);
    endtask

    task automatic fill_linear(input logic [8:0] ins);
        for (int k = 0; k < NMAX; k++) begin
            prog_pc[k]  = 7'(k);
            prog_ins[k] = ins;
        end
    endtask

    task automatic fill_random;
        int         r;
        logic [6:0] cur;
        cur = 7'($urandom_range(0, 127));
        for (int k = 0; k < NMAX; k++) begin
            r = $urandom_range(0, 99);
            if (r >= 25) cur = 7'($urandom_range(0, 127));
            prog_pc[k] = cur;
            r = $urandom_range(0, 99);
            if (r < 4)       prog_ins[k] = 9'h1C0;
            else if (r < 10) prog_ins[k] = 9'h1C0 | 9'($urandom_range(1, 63));
            else             prog_ins[k] = 9'($urandom_range(0, 511));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1; start = 1'b0; prog_sel = 2'd0; pc = '0; instruction = '0;
        tick;
        tick;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_run", core_run, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start_pc", start_pc, 0);
        reset = 1'b0;
        tick;

        // Slot 2, start held for 3 cycles, halt word at RUN cycle 5.
        fill_linear(9'h000);
        prog_ins[5] = 9'h1C0;
        run_prog(2, 3);
        tick;

        // PC stuck at 0x19 from the first cycle: stall detected on the second repeat.
        for (int k = 0; k < NMAX; k++) begin
            prog_pc[k] = 7'h19; prog_ins[k] = 9'h000;
        end
        run_prog(1, 2);
        tick;

        // Near-halt words with nonzero operand bits must not halt, so the run times out.
        fill_linear(9'h1C1);
        run_prog(3, 1);
        tick;

        // Halt word on the exact watchdog cycle: the halt wins.
        fill_linear(9'h000);
        prog_ins[TMO-1] = 9'h1C0;
        run_prog(0, 2);
        tick;

        // Abort a live run with a new start rise, relaunch, then reset mid-run.
        fill_linear(9'h000);
        launch(1, 2);
        for (int k = 0; k < 5; k++) begin
            pc = prog_pc[k]; instruction = prog_ins[k];
            tick;
        end
        start = 1'b1;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_core_run", core_run, 0);
        chk("abort_count", cycle_count, 0);
        start = 1'b0;
        tick;
        chk("relaunch_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            pc = prog_pc[k]; instruction = prog_ins[k];
            tick;
        end
        reset = 1'b1;
        tick;
        chk("midrst_busy", busy, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_count", cycle_count, 0);
        chk("midrst_flags", done | timeout, 0);
        chk("midrst_start_pc", start_pc, 0);
        reset = 1'b0;
        tick;
        tick;

        // Random program traces.
        for (int n = 0; n < 30; n++) begin
            fill_random;
            run_prog($urandom_range(0, 3), $urandom_range(1, 4));
            tick;
        end

        tick;
        tick;
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
